// File: rtl/pipeline_reg_chain.sv
// Elastic pipeline register chain: STAGES valid/data registers, valid/ready
// handshake, global stall, occupancy count. Optional FLUSH via PIPE_CHAIN_FLUSH_EN.
module pipeline_reg_chain #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STAGES     = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = '0,
  localparam int                   OCC_W      = $clog2(STAGES + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  IN_READY,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  input  logic                  OUT_READY,
  input  logic                  STALL,
`ifdef PIPE_CHAIN_FLUSH_EN
  input  logic [STAGES-1:0]     FLUSH,
`endif
  output logic [OCC_W-1:0]      OCCUPANCY
);

  logic [STAGES-1:0]                 valid_q;
  logic [STAGES-1:0]                 valid_d;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data_q;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data_d;
  logic [OCC_W-1:0]                  occ_q;
  logic [OCC_W-1:0]                  occ_d;

  logic [STAGES-1:0]                 rdy;
  logic [STAGES-1:0]                 src_v;
  logic [STAGES-1:0][DATA_WIDTH-1:0] src_d;

  function automatic logic [OCC_W-1:0] popcount(
    input logic [STAGES-1:0] v
  );
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      cnt = cnt + OCC_W'(v[i]);
    end
    return cnt;
  endfunction

  // Ready ripples back from the output; a stage can move if it is empty
  // or its successor can move.
  always_comb begin
    logic r;
    rdy = '0;
    r   = OUT_READY;
    for (int i = STAGES - 1; i >= 0; i--) begin
      r      = !STALL && (!valid_q[i] || r);
      rdy[i] = r;
    end
  end

  // Source of each stage: upstream port for stage 0, previous stage otherwise.
  always_comb begin
    src_v    = '0;
    src_d    = '0;
    src_v[0] = IN_VALID;
    src_d[0] = IN_DATA;
    for (int i = 1; i < STAGES; i++) begin
      src_v[i] = valid_q[i-1];
      src_d[i] = data_q[i-1];
    end
  end

  // Next stage contents: capture when ready, else hold; a kill wins.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < STAGES; i++) begin
      if (rdy[i]) begin
        valid_d[i] = src_v[i];
        data_d[i]  = src_d[i];
      end
`ifdef PIPE_CHAIN_FLUSH_EN
      if (FLUSH[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = NOP_VALUE;
      end
`endif
    end
  end

  // Occupancy tracks the next valid vector exactly, never an inc/dec.
  always_comb begin
    occ_d = popcount(valid_d);
  end

  // Stage and occupancy registers with synchronous reset to empty/NOP.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= NOP_VALUE;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign IN_READY  = rdy[0];
  assign OUT_VALID = valid_q[STAGES-1];
  assign OUT_DATA  = data_q[STAGES-1];
  assign OCCUPANCY = occ_q;

endmodule

// File: tb/tb_pipeline_reg_chain.sv
// Bench for pipeline_reg_chain: directed fill/drain, backpressure, stall,
// reset and flush steps, then random traffic against a reference model.
module tb_pipeline_reg_chain;

  localparam int          S   = 3;
  localparam logic [31:0] NOP = 32'hDEAD_0000;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          IN_VALID;
  logic [31:0]   IN_DATA;
  logic          IN_READY;
  logic          OUT_VALID;
  logic [31:0]   OUT_DATA;
  logic          OUT_READY;
  logic          STALL;
  logic [S-1:0]  FLUSH;
  logic [1:0]    OCCUPANCY;

  int total = 0;
  int bad   = 0;

  bit          mv[S];
  logic [31:0] md[S];
  logic [31:0] sb[$];

  always #5 CLK = ~CLK;

  pipeline_reg_chain #(
    .DATA_WIDTH (32),
    .STAGES     (S),
    .NOP_VALUE  (NOP)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_DATA   (IN_DATA),
    .IN_READY  (IN_READY),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA),
    .OUT_READY (OUT_READY),
    .STALL     (STALL),
`ifdef PIPE_CHAIN_FLUSH_EN
    .FLUSH     (FLUSH),
`endif
    .OCCUPANCY (OCCUPANCY)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A stage may advance if not stalled and either the sink accepts or
  // there is a hole somewhere at or after it.
  function automatic bit mready(int i);
    if (STALL) return 1'b0;
    if (OUT_READY) return 1'b1;
    for (int j = i; j < S; j++) begin
      if (!mv[j]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] mocc();
    int n;
    n = 0;
    for (int i = 0; i < S; i++) n += int'(mv[i]);
    return n;
  endfunction

  task automatic step(bit iv, logic [31:0] id, bit ordy,
                      bit stl, bit rst, logic [S-1:0] fl);
    bit          nv[S];
    logic [31:0] nd[S];
    bit          r[S];
    IN_VALID  = iv;
    IN_DATA   = id;
    OUT_READY = ordy;
    STALL     = stl;
    RESET     = rst;
    FLUSH     = fl;
    #1;
    for (int i = 0; i < S; i++) r[i] = mready(i);
    check("in_ready", {31'd0, IN_READY}, {31'd0, r[0]});
`ifndef PIPE_CHAIN_FLUSH_EN
    if (rst) begin
      sb.delete();
    end else begin
      if (mv[S-1] && ordy && !stl) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL order observed=%h expected=none", OUT_DATA);
        end else begin
          check("order", OUT_DATA, sb.pop_front());
        end
      end
      if (iv && r[0]) sb.push_back(id);
    end
`endif
    for (int i = 0; i < S; i++) begin
      nv[i] = mv[i];
      nd[i] = md[i];
      if (r[i]) begin
        if (i == 0) begin
          nv[i] = iv;
          nd[i] = id;
        end else begin
          nv[i] = mv[i-1];
          nd[i] = md[i-1];
        end
      end
`ifdef PIPE_CHAIN_FLUSH_EN
      if (fl[i]) begin
        nv[i] = 1'b0;
        nd[i] = NOP;
      end
`endif
      if (rst) begin
        nv[i] = 1'b0;
        nd[i] = NOP;
      end
    end
    @(posedge CLK);
    #1;
    mv = nv;
    md = nd;
    check("out_valid", {31'd0, OUT_VALID}, {31'd0, mv[S-1]});
    check("out_data", OUT_DATA, md[S-1]);
    check("occupancy", {30'd0, OCCUPANCY}, mocc());
  endtask

  initial begin
    RESET     = 1'b1;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    OUT_READY = 1'b0;
    STALL     = 1'b0;
    FLUSH     = '0;
    for (int i = 0; i < S; i++) begin
      mv[i] = 1'b0;
      md[i] = NOP;
    end
    @(posedge CLK);
    #1;
    check("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_data", OUT_DATA, NOP);
    check("rst_occ", {30'd0, OCCUPANCY}, 32'd0);
    step(0, 0, 1, 0, 1, '0);

    // fill/drain
    step(1, 32'h11, 1, 0, 0, '0);
    step(1, 32'h22, 1, 0, 0, '0);
    step(1, 32'h33, 1, 0, 0, '0);
    check("fill_e3", OUT_DATA, 32'h11);
    step(0, 0, 1, 0, 0, '0);
    check("fill_e4", OUT_DATA, 32'h22);
    step(0, 0, 1, 0, 0, '0);
    check("fill_e5", OUT_DATA, 32'h33);
    step(0, 0, 1, 0, 0, '0);
    check("drained", {30'd0, OCCUPANCY}, 32'd0);

    // backpressure
    for (int k = 0; k < 4; k++) step(1, 32'hA0 + k, 0, 0, 0, '0);
    check("bp_occ", {30'd0, OCCUPANCY}, S);
    check("bp_ready", {31'd0, IN_READY}, 32'd0);
    check("bp_head", OUT_DATA, 32'hA0);
    for (int k = 0; k < 5; k++) step(k == 0, 32'hA3, 1, 0, 0, '0);

    // stall pulse mid-stream
    for (int k = 0; k < 8; k++) begin
      step(1, 32'hB0 + k, 1, (k >= 2 && k < 6), 0, '0);
    end
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0, '0);

    // reset while full and stalled
    for (int k = 0; k < 3; k++) step(1, 32'hC0 + k, 0, 0, 0, '0);
    step(1, 32'hCF, 1, 1, 1, '0);
    check("rstfull_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rstfull_occ", {30'd0, OCCUPANCY}, 32'd0);
    check("rstfull_data", OUT_DATA, NOP);

`ifdef PIPE_CHAIN_FLUSH_EN
    // stage2=C, stage1=B, stage0=A; kill stages 0 and 1 while D arrives
    step(1, 32'hCC, 0, 0, 0, '0);
    step(1, 32'hBB, 0, 0, 0, '0);
    step(1, 32'hAA, 0, 0, 0, '0);
    step(1, 32'hDD, 1, 0, 0, 3'b011);
    check("flush_occ", {30'd0, OCCUPANCY}, 32'd1);
    check("flush_out", OUT_DATA, 32'hBB);
    check("flush_mid", dut.data_q[1], NOP);
`endif

    // random traffic
    for (int k = 0; k < 5000; k++) begin
      logic [S-1:0] fl;
      fl = '0;
`ifdef PIPE_CHAIN_FLUSH_EN
      for (int i = 0; i < S; i++) fl[i] = ($urandom_range(0, 19) == 0);
`endif
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0, fl);
    end
    for (int k = 0; k < 2 * S; k++) step(0, 0, 1, 0, 0, '0);
`ifndef PIPE_CHAIN_FLUSH_EN
    check("sb_left", sb.size(), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
